escalonador_chamadas: RTL and testbench
=======================================

ESCALONADOR_CHAMADAS -- requirements
Module: escalonador_chamadas

Interface
REQ-001 SHALL have parameter: TEMPO_PORTA, 8, door-open dwell in clock cycles (legal range 1..255).
REQ-002 SHALL have port: clock_in  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: botoes  input  4  call buttons, bit i = floor i, level-sensitive.
REQ-005 SHALL have port: andar  input  2  current floor reported by the floor controller.
REQ-006 SHALL have port: seletor_andar  output  2  registered target floor driven to the floor controller.
REQ-007 SHALL have port: porta_aberta  output  1  registered, high while the door dwell is active.
REQ-008 SHALL have port: pedidos  output  4  registered pending-call vector.
REQ-009 SHALL have port: ocupado  output  1  high when state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, MOVENDO, PORTA; only one state active per cycle.
REQ-011 SHALL set pedidos[i] on a cycle with botoes[i]=1, visible the next cycle; bits stay set until served.
REQ-012 SHALL, in IDLE with pedidos!=0, load seletor_andar with the selected floor (REQ-017) and go to MOVENDO; button to seletor_andar latency = 2 cycles.
REQ-013 SHALL, in MOVENDO when andar==seletor_andar, clear pedidos[andar], set porta_aberta, load timer with TEMPO_PORTA-1, go to PORTA; this also covers a target equal to the current floor (arrival after one MOVENDO cycle).
REQ-014 SHALL, in PORTA, decrement the timer each cycle; at timer==0 clear porta_aberta and go to IDLE; porta_aberta high exactly TEMPO_PORTA cycles.
REQ-015 SHALL ignore botoes[andar] while in PORTA (not latched); presses for other floors latch normally.
REQ-016 SHALL give clear priority over set when clear and press of the same bit coincide.
REQ-017 SHALL, without PRIORIDADE_DIRECAO_EN, select the lowest-index set bit of pedidos.
REQ-018 SHALL hold seletor_andar constant during MOVENDO and PORTA; new calls never retarget a trip in progress.
REQ-019 SHALL keep a 1-bit direcao register (1 = up), updated on every IDLE->MOVENDO transition: 1 if target>andar, 0 if target<andar, unchanged if equal.

Reset
REQ-020 SHALL on reset: state IDLE, pedidos=0000, seletor_andar=00, porta_aberta=0, timer=0, direcao=1, ocupado=0.
REQ-021 SHALL let reset override all activity in any state, including mid-trip and mid-dwell; botoes asserted during reset are not latched.

Configuration
REQ-022 SHALL compile direction-priority selection only when macro PRIORIDADE_DIRECAO_EN is defined.
REQ-023 SHALL, with PRIORIDADE_DIRECAO_EN, select: pedidos[andar] if set; else if direcao=1 the lowest pending floor >andar, else the highest pending floor <andar; if none in that direction, the nearest pending floor in the opposite direction.
REQ-024 SHALL, without PRIORIDADE_DIRECAO_EN, use REQ-017 only and compile no direction-selection logic (direcao register still present).

Verification
REQ-025 SHALL cover: reset, botoes=0100 one cycle, andar driven 0->1->2 -> seletor_andar=10 two cycles after press, porta_aberta high 8 cycles after andar=10, pedidos=0000 after.
REQ-026 SHALL cover: andar=01 idle, botoes=0010 -> MOVENDO one cycle, then PORTA, pedidos[1] cleared, door 8 cycles.
REQ-027 SHALL cover: in PORTA at andar=10, botoes=0100 -> not latched; botoes=1000 -> pedidos=1000, served after door closes.
REQ-028 SHALL cover: pedidos=1001 at andar=01, direcao=1 -> without macro target 00; with PRIORIDADE_DIRECAO_EN target 11.
REQ-029 SHALL cover: reset asserted on 3rd cycle of PORTA -> next cycle all outputs at REQ-020 values.
REQ-030 SHALL cover: TEMPO_PORTA=1 -> porta_aberta high exactly 1 cycle.

Source files
------------

// File: rtl/escalonador_chamadas.sv
// escalonador_chamadas: call scheduler for a four-floor car (IDLE -> MOVENDO -> PORTA).
// Optional macro PRIORIDADE_DIRECAO_EN selects direction-priority targeting instead of lowest floor.
module escalonador_chamadas #(
  parameter int unsigned TEMPO_PORTA = 8
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic [1:0] andar,
  output logic [1:0] seletor_andar,
  output logic       porta_aberta,
  output logic [3:0] pedidos,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVENDO = 2'd1,
    PORTA   = 2'd2
  } estado_t;

  localparam logic [7:0] TIMER_CARGA = 8'(TEMPO_PORTA - 1);

  estado_t    estado;
  logic [7:0] timer;
  logic       direcao;
  logic [1:0] alvo;
  logic [3:0] andar_onehot;
  logic [3:0] mascara_set;
  logic [3:0] mascara_clr;
  logic       chegou;

`ifdef PRIORIDADE_DIRECAO_EN
  // Serve the current floor first, then keep going the way we were heading, else turn around.
  function automatic logic [1:0] escolhe_alvo(input logic [3:0] p, input logic [1:0] a,
                                               input logic dir);
    logic [1:0] acima;
    logic [1:0] abaixo;
    logic       tem_acima;
    logic       tem_abaixo;
    logic [1:0] r;
    acima      = 2'd0;
    abaixo     = 2'd0;
    tem_acima  = 1'b0;
    tem_abaixo = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i] && (2'(i) > a)) begin
        acima     = 2'(i);
        tem_acima = 1'b1;
      end else begin
        acima = acima;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (p[i] && (2'(i) < a)) begin
        abaixo     = 2'(i);
        tem_abaixo = 1'b1;
      end else begin
        abaixo = abaixo;
      end
    end
    if (p[a]) begin
      r = a;
    end else if (dir) begin
      r = tem_acima ? acima : abaixo;
    end else begin
      r = tem_abaixo ? abaixo : acima;
    end
    return r;
  endfunction

  assign alvo = escolhe_alvo(pedidos, andar, direcao);
`else
  function automatic logic [1:0] menor_pedido(input logic [3:0] p);
    logic [1:0] r;
    casez (p)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign alvo = menor_pedido(pedidos);
`endif

  assign ocupado = (estado != IDLE);

  // Request set/clear masks: own-floor presses are dropped during the dwell, arrival clears.
  always_comb begin
    andar_onehot = 4'b0001 << andar;
    chegou       = (estado == MOVENDO) && (andar == seletor_andar);
    if (estado == PORTA) begin
      mascara_set = botoes & ~andar_onehot;
    end else begin
      mascara_set = botoes;
    end
    if (chegou) begin
      mascara_clr = andar_onehot;
    end else begin
      mascara_clr = 4'b0000;
    end
  end

  // Scheduler state, pending calls, dwell timer and travel direction.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      estado        <= IDLE;
      pedidos       <= 4'b0000;
      seletor_andar <= 2'b00;
      porta_aberta  <= 1'b0;
      timer         <= 8'd0;
      direcao       <= 1'b1;
    end else begin
      // Clear wins over a coincident press of the same floor.
      pedidos <= (pedidos | mascara_set) & ~mascara_clr;
      case (estado)
        IDLE: begin
          if (pedidos != 4'b0000) begin
            seletor_andar <= alvo;
            direcao       <= (alvo == andar) ? direcao : (alvo > andar);
            estado        <= MOVENDO;
          end
        end
        MOVENDO: begin
          if (chegou) begin
            porta_aberta <= 1'b1;
            timer        <= TIMER_CARGA;
            estado       <= PORTA;
          end
        end
        PORTA: begin
          if (timer == 8'd0) begin
            porta_aberta <= 1'b0;
            estado       <= IDLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          porta_aberta <= 1'b0;
          estado       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_chamadas.sv
// Table-driven bench for escalonador_chamadas; expectations follow PRIORIDADE_DIRECAO_EN when defined.
module tb_escalonador_chamadas;

  logic       clock_in = 1'b0;
  logic       reset, reset1;
  logic [3:0] botoes, botoes1;
  logic [1:0] andar, andar1;
  logic [1:0] seletor_andar, seletor_andar1;
  logic       porta_aberta, porta_aberta1;
  logic [3:0] pedidos, pedidos1;
  logic       ocupado, ocupado1;

  int n_vec = 0;
  int n_err = 0;

`ifdef PRIORIDADE_DIRECAO_EN
  localparam logic [1:0] TGT = 2'b11;
  localparam logic [3:0] REM = 4'b0001;
  localparam logic [1:0] OTH = 2'b00;
`else
  localparam logic [1:0] TGT = 2'b00;
  localparam logic [3:0] REM = 4'b1000;
  localparam logic [1:0] OTH = 2'b11;
`endif

  escalonador_chamadas #(.TEMPO_PORTA(8)) dut (
    .clock_in(clock_in), .reset(reset), .botoes(botoes), .andar(andar),
    .seletor_andar(seletor_andar), .porta_aberta(porta_aberta),
    .pedidos(pedidos), .ocupado(ocupado)
  );

  escalonador_chamadas #(.TEMPO_PORTA(1)) dut1 (
    .clock_in(clock_in), .reset(reset1), .botoes(botoes1), .andar(andar1),
    .seletor_andar(seletor_andar1), .porta_aberta(porta_aberta1),
    .pedidos(pedidos1), .ocupado(ocupado1)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic       r;
    logic [3:0] b;
    logic [1:0] a;
    logic [1:0] es;
    logic       ep;
    logic [3:0] eped;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] b, input logic [1:0] a,
                     input logic [1:0] es, input logic ep, input logic [3:0] eped,
                     input logic eo);
    vec_t v;
    v.r = r; v.b = b; v.a = a; v.es = es; v.ep = ep; v.eped = eped; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check1(input string nome, input logic ep, input logic eo);
    n_vec++;
    if (porta_aberta1 !== ep || ocupado1 !== eo) begin
      n_err++;
      $display("FAIL %s: porta=%b ocupado=%b, required porta=%b ocupado=%b",
               nome, porta_aberta1, ocupado1, ep, eo);
    end
  endtask

  initial begin
    reset = 1'b1; botoes = 4'b0000; andar = 2'b00;
    reset1 = 1'b1; botoes1 = 4'b0000; andar1 = 2'b00;

    // Trip 0 -> 2, own-floor press during dwell ignored, floor 3 latched and served after.
    add(1'b1, 4'b0000, 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    add(1'b1, 4'b1111, 2'd0, 2'b00, 1'b0, 4'b0000, 1'b0);
    add(1'b0, 4'b0100, 2'd0, 2'b00, 1'b0, 4'b0100, 1'b0);
    add(1'b0, 4'b0000, 2'd0, 2'b10, 1'b0, 4'b0100, 1'b1);
    add(1'b0, 4'b0000, 2'd1, 2'b10, 1'b0, 4'b0100, 1'b1);
    add(1'b0, 4'b0100, 2'd2, 2'b10, 1'b1, 4'b0000, 1'b1);
    add(1'b0, 4'b0100, 2'd2, 2'b10, 1'b1, 4'b0000, 1'b1);
    add(1'b0, 4'b1000, 2'd2, 2'b10, 1'b1, 4'b1000, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 4'b0000, 2'd2, 2'b10, 1'b1, 4'b1000, 1'b1);
    add(1'b0, 4'b0000, 2'd2, 2'b10, 1'b0, 4'b1000, 1'b0);
    add(1'b0, 4'b0000, 2'd2, 2'b11, 1'b0, 4'b1000, 1'b1);
    add(1'b0, 4'b0000, 2'd3, 2'b11, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0000, 2'd3, 2'b11, 1'b1, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 2'd3, 2'b11, 1'b0, 4'b0000, 1'b0);
    // Call at the current floor: one MOVENDO cycle then the dwell.
    add(1'b0, 4'b0010, 2'd1, 2'b11, 1'b0, 4'b0010, 1'b0);
    add(1'b0, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b0010, 1'b1);
    add(1'b0, 4'b0000, 2'd1, 2'b01, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0000, 2'd1, 2'b01, 1'b1, 4'b0000, 1'b1);
    add(1'b0, 4'b0000, 2'd1, 2'b01, 1'b0, 4'b0000, 1'b0);
    // Two calls either side of floor 1 while heading up.
    add(1'b0, 4'b1001, 2'd1, 2'b01, 1'b0, 4'b1001, 1'b0);
    add(1'b0, 4'b0000, 2'd1, TGT,   1'b0, 4'b1001, 1'b1);
    add(1'b0, 4'b0000, TGT,  TGT,   1'b1, REM,     1'b1);
    for (int i = 0; i < 7; i++) add(1'b0, 4'b0000, TGT, TGT, 1'b1, REM, 1'b1);
    add(1'b0, 4'b0000, TGT,  TGT,   1'b0, REM,     1'b0);
    add(1'b0, 4'b0000, TGT,  OTH,   1'b0, REM,     1'b1);
    // Reset on the third dwell cycle wipes everything, including a fresh call.
    add(1'b0, 4'b0000, OTH,  OTH,   1'b1, 4'b0000, 1'b1);
    add(1'b0, 4'b0010, OTH,  OTH,   1'b1, 4'b0010, 1'b1);
    add(1'b1, 4'b1111, OTH,  2'b00, 1'b0, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, OTH,  2'b00, 1'b0, 4'b0000, 1'b0);

    @(posedge clock_in); #1;
    foreach (vecs[k]) begin
      reset = vecs[k].r; botoes = vecs[k].b; andar = vecs[k].a;
      @(posedge clock_in); #1;
      n_vec++;
      if (seletor_andar !== vecs[k].es || porta_aberta !== vecs[k].ep ||
          pedidos !== vecs[k].eped || ocupado !== vecs[k].eo) begin
        n_err++;
        $display("FAIL vec %0d: sel=%b porta=%b ped=%b ocup=%b, required sel=%b porta=%b ped=%b ocup=%b",
                 k, seletor_andar, porta_aberta, pedidos, ocupado,
                 vecs[k].es, vecs[k].ep, vecs[k].eped, vecs[k].eo);
      end
    end

    // One-cycle dwell on the TEMPO_PORTA=1 instance.
    reset1 = 1'b1; @(posedge clock_in); #1;
    check1("t1_reset", 1'b0, 1'b0);
    reset1 = 1'b0; botoes1 = 4'b0001; andar1 = 2'd0;
    @(posedge clock_in); #1;
    botoes1 = 4'b0000;
    @(posedge clock_in); #1;
    check1("t1_moving", 1'b0, 1'b1);
    @(posedge clock_in); #1;
    check1("t1_door_open", 1'b1, 1'b1);
    @(posedge clock_in); #1;
    check1("t1_door_closed", 1'b0, 1'b0);
    n_vec++;
    if (pedidos1 !== 4'b0000) begin
      n_err++;
      $display("FAIL t1_pedidos: got %b, required 0000", pedidos1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
